// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared state encoding and sizing helpers for the wide add sequencer
package wide_add_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   function automatic int idx_w(input int chunks);
      return (chunks > 2) ? $clog2(chunks) : 1;
   endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational WIDTH-bit slice with carry in and carry out
module chunk_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);
   assign {co, s} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: WIDTH*CHUNKS-bit add/subtract, one slice per cycle, LSB chunk first
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int CHUNKS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH*CHUNKS-1:0]   a,
   input  logic [WIDTH*CHUNKS-1:0]   b,
   input  logic                      cin,
   input  logic                      sub,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH*CHUNKS-1:0]   result,
   output logic                      cout,
   output logic                      ovf
);
   localparam int N  = WIDTH * CHUNKS;
   localparam int IW = idx_w(CHUNKS);
   state_t          state;
   logic [N-1:0]    ar, br;
   logic            carry;
   logic [IW-1:0]   idx;
   logic [WIDTH-1:0] s;
   logic            co;
   logic            last;
   chunk_adder #(.WIDTH(WIDTH)) u_slice (
      .x (ar[WIDTH-1:0]),
      .y (br[WIDTH-1:0]),
      .ci(carry),
      .s (s),
      .co(co)
   );
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign last      = (idx == IW'(CHUNKS - 1));
   // sequencer: latch operands, run one slice per cycle, hold result until consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ar     <= '0;
         br     <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               ar    <= a;
               br    <= sub ? ~b : b;
               carry <= sub | cin;
               idx   <= '0;
               state <= RUN;
            end
            RUN: begin
               for (int i = 0; i < CHUNKS; i++)
                  if (idx == IW'(i)) result[i*WIDTH +: WIDTH] <= s;
               carry <= co;
               ar    <= ar >> WIDTH;
               br    <= br >> WIDTH;
               idx   <= idx + IW'(1);
               if (last) begin
                  cout  <= co;
                  ovf   <= (ar[WIDTH-1] == br[WIDTH-1]) & (s[WIDTH-1] != ar[WIDTH-1]);
                  state <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: randomized and directed checks of wide_add_seq against an arithmetic model
module tb_wide_add_seq;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [31:0] a, b, result;
   int          n_chk = 0, n_pass = 0;

   wide_add_seq #(.WIDTH(8), .CHUNKS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // reference: {ovf, cout, result} from plain integer arithmetic on the 32-bit operands
   function automatic logic [33:0] model(input logic [31:0] x, y, input logic c, s);
      longint ux, uy, sx, sy, uv, sv;
      logic   co, ov;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      uv = s ? ux - uy : ux + uy + longint'(c);
      sv = s ? sx - sy : sx + sy + longint'(c);
      co = s ? (ux >= uy) : (uv >= 64'sd4294967296);
      ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      return {ov, co, uv[31:0]};
   endfunction

   task automatic go(input logic [31:0] x, y, input logic c, s);
      a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_chk++;
      if ({in_ready, out_valid, cout, ovf, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0})
         $display("FAIL reset: got rdy=%b vld=%b co=%b ov=%b r=%h expected 1 0 0 0 0",
                  in_ready, out_valid, cout, ovf, result);
      else n_pass++;
   endtask

   task automatic test_directed();
      logic [31:0] ta [5] = '{32'h000000FF, 32'hFFFFFFFF, 32'd5, 32'd7, 32'h7FFFFFFF};
      logic [31:0] tb [5] = '{32'h00000001, 32'h00000000, 32'd7, 32'd5, 32'h00000001};
      logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [33:0] exp [5] = '{{2'b00, 32'h00000100}, {2'b01, 32'h00000000},
                               {2'b00, 32'hFFFFFFFE}, {2'b01, 32'h00000002},
                               {2'b10, 32'h80000000}};
      int lat;
      for (int i = 0; i < 5; i++) begin
         go(ta[i], tb[i], tc[i], ts[i]);
         wait_done(lat);
         n_chk++;
         if ({ovf, cout, result} !== exp[i])
            $display("FAIL dir%0d: got ovf/cout/result %h expected %h", i, {ovf, cout, result}, exp[i]);
         else n_pass++;
         n_chk++;
         if (lat !== 4) $display("FAIL dir%0d latency: got %0d expected 4", i, lat);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_random();
      logic [31:0] x, y;
      logic        c, s;
      logic [33:0] exp;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         x = $urandom; y = $urandom; c = 1'($urandom); s = 1'($urandom);
         if (i % 8 == 0) y = x;
         if (i % 8 == 1) x = 32'hFFFFFFFF;
         if (i % 8 == 2) begin x = 32'h80000000; y = 32'h80000000; end
         exp = model(x, y, c, s);
         go(x, y, c, s);
         wait_done(lat);
         n_chk++;
         if ({ovf, cout, result} !== exp)
            $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b: got %h expected %h",
                     i, x, y, c, s, {ovf, cout, result}, exp);
         else n_pass++;
         n_chk++;
         if (lat !== 4) $display("FAIL rand%0d latency: got %0d expected 4", i, lat);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_backpressure();
      logic [33:0] exp0, exp1;
      int          lat;
      exp0 = model(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0);
      exp1 = model(32'h00001000, 32'h00002000, 1'b0, 1'b1);
      go(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0);
      wait_done(lat);
      a = 32'h00001000; b = 32'h00002000; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if ({in_ready, out_valid, ovf, cout, result} !== {1'b0, 1'b1, exp0})
            $display("FAIL bp_hold%0d: got rdy=%b vld=%b %h expected rdy=0 vld=1 %h",
                     i, in_ready, out_valid, {ovf, cout, result}, exp0);
         else n_pass++;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_chk++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL bp_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
      else n_pass++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_chk++;
      if (in_ready !== 1'b0) $display("FAIL bp_accept: got rdy=%b expected 0", in_ready);
      else n_pass++;
      wait_done(lat);
      n_chk++;
      if ({ovf, cout, result} !== exp1)
         $display("FAIL bp_new: got %h expected %h", {ovf, cout, result}, exp1);
      else n_pass++;
      n_chk++;
      if (lat !== 4) $display("FAIL bp_new latency: got %0d expected 4", lat);
      else n_pass++;
      consume();
   endtask

   task automatic test_reset_mid();
      logic seen;
      int   lat;
      go(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_chk++;
      if ({in_ready, out_valid, cout, ovf, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0})
         $display("FAIL mid_reset: got rdy=%b vld=%b co=%b ov=%b r=%h expected 1 0 0 0 0",
                  in_ready, out_valid, cout, ovf, result);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         seen |= out_valid;
      end
      n_chk++;
      if (seen !== 1'b0) $display("FAIL mid_no_valid: got out_valid pulse %b expected 0", seen);
      else n_pass++;
      go(32'd3, 32'd4, 1'b0, 1'b0);
      wait_done(lat);
      n_chk++;
      if ({out_valid, result} !== {1'b1, 32'd7})
         $display("FAIL mid_followup: got vld=%b r=%h expected 1 00000007", out_valid, result);
      else n_pass++;
      consume();
   endtask

   task automatic test_back_to_back();
      logic [31:0] cx, cy, nx, ny;
      logic        cc, cs, nc, ns;
      logic [33:0] exp;
      int          lat;
      out_ready = 1'b1;
      cx = $urandom; cy = $urandom; cc = 1'($urandom); cs = 1'($urandom);
      a = cx; b = cy; cin = cc; sub = cs; in_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         nx = $urandom; ny = $urandom; nc = 1'($urandom); ns = 1'($urandom);
         a = nx; b = ny; cin = nc; sub = ns;
         if (i == 5) in_valid = 1'b0;
         exp = model(cx, cy, cc, cs);
         wait_done(lat);
         n_chk++;
         if ({ovf, cout, result} !== exp)
            $display("FAIL b2b%0d: got %h expected %h", i, {ovf, cout, result}, exp);
         else n_pass++;
         n_chk++;
         if (lat !== 4) $display("FAIL b2b%0d latency: got %0d expected 4", i, lat);
         else n_pass++;
         @(posedge clk); #1;
         n_chk++;
         if (in_ready !== 1'b1) $display("FAIL b2b%0d idle: got rdy=%b expected 1", i, in_ready);
         else n_pass++;
         @(posedge clk); #1;
         cx = nx; cy = ny; cc = nc; cs = ns;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
